// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks a camera register table in ROM and turns each entry into an SCCB write
module cam_cfg_sequencer #(
    parameter int ROM_AW       = 8,
    parameter int DELAY_CYCLES = 250_000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_start,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_sccb_start,
    output logic [7:0]        o_sccb_addr,
    output logic [7:0]        o_sccb_data,
    input  logic              i_sccb_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);
    // Extra counter bit: the delay ends when the count drops below zero,
    // giving DELAY_CYCLES+1 cycles from a load of DELAY_CYCLES-1.
    localparam int                CW       = $clog2(DELAY_CYCLES) + 1;
    localparam logic [CW-1:0]     DLY_LOAD = CW'(DELAY_CYCLES - 1);
    localparam logic [15:0]       END_MARK = 16'hFFFF;
    localparam logic [15:0]       DLY_MARK = 16'hFFF0;
    localparam logic [ROM_AW-1:0] LAST     = '1;

    typedef enum logic [2:0] {IDLE, FETCH, ROMWAIT, DECODE, SEND, ACKWAIT, DELAY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          advance;

    // Current entry finished: ack after the pulse cycle, or delay counter underflowed
    always_comb advance = (state == ACKWAIT && !o_sccb_start && i_sccb_ready) ||
                          (state == DELAY && cnt[CW-1]);

    // Sequencer FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            o_rom_addr   <= '0;
            o_sccb_start <= 1'b0;
            o_sccb_addr  <= '0;
            o_sccb_data  <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_sccb_start <= 1'b0;
            case (state)
                IDLE, DONE: if (i_cfg_start) begin
                    state      <= FETCH;
                    o_rom_addr <= '0;
                    o_done     <= 1'b0;
                    o_overrun  <= 1'b0;
                    o_busy     <= 1'b1;
                end
                FETCH:   state <= ROMWAIT;
                ROMWAIT: state <= DECODE;
                DECODE: if (i_rom_data == END_MARK) begin
                    state  <= DONE;
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                end else if (i_rom_data == DLY_MARK) begin
                    state <= DELAY;
                    cnt   <= DLY_LOAD;
                end else begin
                    state       <= SEND;
                    o_sccb_addr <= i_rom_data[15:8];
                    o_sccb_data <= i_rom_data[7:0];
                end
                SEND: if (i_sccb_ready) begin
                    state        <= ACKWAIT;
                    o_sccb_start <= 1'b1;
                end
                ACKWAIT: ;
                DELAY:   cnt <= cnt - CW'(1);
                default: state <= IDLE;
            endcase
            if (advance) begin
                if (o_rom_addr == LAST) begin
                    state     <= DONE;
                    o_overrun <= 1'b1;
                    o_done    <= 1'b1;
                    o_busy    <= 1'b0;
                end else begin
                    state      <= FETCH;
                    o_rom_addr <= o_rom_addr + ROM_AW'(1);
                end
            end
        end
    end
endmodule
